// File: rtl/regfile_wb_arbiter.sv
// Purpose : round-robin arbiter sharing the register-file write port between ALU, load and mul/div.
// Latency : 1 cycle from accepted request to rf_we/rf_rdc/rf_rd; hazard is combinational from busy_map.
// Backpr. : one req_ready per cycle, in rotating order; a source waits at most NREQ-1 cycles.
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   ena                        block enable; when low nothing changes and req_ready is 0
//   req_valid/req_rdc/req_rd   per-source write-back request: valid, destination, data (packed per source)
//   req_ready                  one-hot grant, combinational
//   issue_valid/issue_rdc      decode marks a destination register as pending
//   chk_rsc/chk_rtc, hazard    decode source registers and their pending-write indication
//   rf_we/rf_rdc/rf_rd         registered register-file write port
//   busy_map                   pending-write scoreboard, bit 0 always 0
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*AW-1:0]    req_rdc,
    input  logic [NREQ*DW-1:0]    req_rd,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rdc,
    input  logic [AW-1:0]         chk_rsc,
    input  logic [AW-1:0]         chk_rtc,
    output logic                  hazard,
    output logic                  rf_we,
    output logic [AW-1:0]         rf_rdc,
    output logic [DW-1:0]         rf_rd,
    output logic [(1<<AW)-1:0]    busy_map
);

    localparam int NREG = 1 << AW;

    logic [1:0]      last_q,   last_d;
    logic            rf_we_q,  rf_we_d;
    logic [AW-1:0]   rf_rdc_q, rf_rdc_d;
    logic [DW-1:0]   rf_rd_q,  rf_rd_d;
    logic [NREG-1:0] busy_q,   busy_d;

    logic            xfer;
    logic [1:0]      gnt_idx;
    logic [AW-1:0]   gnt_rdc;
    logic [DW-1:0]   gnt_rd;

    // Round-robin search starting one past the last winner. Since ready is only
    // raised on a valid source, any ready bit means a transfer at the next edge.
    always_comb begin
        logic [2:0] sum;
        logic [1:0] idx;
        req_ready = '0;
        xfer      = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        idx       = '0;
        if (ena) begin
            for (int k = 1; k <= NREQ; k++) begin
                sum = {1'b0, last_q} + 3'(k);
                if (sum >= 3'(NREQ)) begin
                    sum = sum - 3'(NREQ);
                end
                idx = sum[1:0];
                if (!xfer && req_valid[idx]) begin
                    xfer           = 1'b1;
                    gnt_idx        = idx;
                    req_ready[idx] = 1'b1;
                end
            end
        end
    end

    // Select the winner's destination and data.
    always_comb begin
        gnt_rdc = '0;
        gnt_rd  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                gnt_rdc = req_rdc[i*AW +: AW];
                gnt_rd  = req_rd[i*DW +: DW];
            end
        end
    end

    always_comb begin
        last_d   = last_q;
        rf_we_d  = rf_we_q;
        rf_rdc_d = rf_rdc_q;
        rf_rd_d  = rf_rd_q;
        busy_d   = busy_q;
        if (ena) begin
            rf_we_d = 1'b0;
            if (xfer) begin
                last_d = gnt_idx;
                // r0 is hardwired zero: the request is consumed but never written.
                if (gnt_rdc != '0) begin
                    rf_we_d  = 1'b1;
                    rf_rdc_d = gnt_rdc;
                    rf_rd_d  = gnt_rd;
                end
                busy_d[gnt_rdc] = 1'b0;
            end
            // Applied after the clear so a same-cycle issue to the same register keeps it pending.
            if (issue_valid && (issue_rdc != '0)) begin
                busy_d[issue_rdc] = 1'b1;
            end
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= 2'(NREQ - 1);
            rf_we_q  <= 1'b0;
            rf_rdc_q <= '0;
            rf_rd_q  <= '0;
            busy_q   <= '0;
        end else begin
            last_q   <= last_d;
            rf_we_q  <= rf_we_d;
            rf_rdc_q <= rf_rdc_d;
            rf_rd_q  <= rf_rd_d;
            busy_q   <= busy_d;
        end
    end

    // No bypass: a clear takes effect on the registered map, i.e. next cycle.
    assign hazard   = busy_q[chk_rsc] | busy_q[chk_rtc];
    assign rf_we    = rf_we_q;
    assign rf_rdc   = rf_rdc_q;
    assign rf_rd    = rf_rd_q;
    assign busy_map = busy_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between three write-back sources: ALU (0), load unit (1), mul/div unit (2).
- Round-robin arbitration; the winning request is registered onto the register-file write port.
- Keeps a 32-entry pending-write scoreboard, set at issue and cleared at grant, and reports read hazards so the decode stage can stall.

Parameters:
- NREQ, 3, number of write-back requesters; fixed at 3 in this revision.
- DW, 32, data width.
- AW, 5, register address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- ena  input  1  block enable; when low: no grants, no scoreboard updates, outputs hold.
- req_valid  input  3  per-source write request; bit i = source i.
- req_rdc  input  15  per-source destination register; source i uses bits [5i+4:5i].
- req_rd  input  96  per-source write data; source i uses bits [32i+31:32i].
- req_ready  output  3  one-hot grant; combinational from current inputs and state.
- issue_valid  input  1  decode is issuing an instruction that writes a register.
- issue_rdc  input  5  destination register of the issued instruction.
- chk_rsc  input  5  decode source register s.
- chk_rtc  input  5  decode source register t.
- hazard  output  1  chk_rsc or chk_rtc has a pending write.
- rf_we  output  1  register-file write enable (registered).
- rf_rdc  output  5  register-file write address (registered).
- rf_rd  output  32  register-file write data (registered).
- busy_map  output  32  scoreboard pending bits; bit 0 always 0.

Behaviour:
- Reset (rst high at posedge, regardless of ena):
  - rf_we=0, rf_rdc=0, rf_rd=0, busy_map=0.
  - Round-robin pointer last=2, so source 0 has highest priority first.
- Arbitration (combinational, only when ena=1):
  - Search order starts at (last+1) mod 3 and wraps.
  - The first source with req_valid set gets req_ready[i]=1; all other ready bits are 0.
  - With ena=0 or no valid request, req_ready=000.
- Handshake:
  - Transfer occurs when req_valid[i] and req_ready[i] are both high at a posedge.
  - The source holds req_rdc/req_rd stable while valid is high and ready is low.
  - The source may not drop valid before the transfer.
- Write port, latency 1 cycle:
  - On a transfer: rf_we<=1, rf_rdc<=granted rdc, rf_rd<=granted data, last<=i.
  - Otherwise rf_we<=0; rf_rdc/rf_rd hold their previous values.
  - A transfer with rdc=0 is accepted (ready asserted, pointer advances) but rf_we<=0.
- Scoreboard:
  - Transfer with rdc=r clears bit r.
  - issue_valid with issue_rdc=r (r≠0) sets bit r.
  - Set and clear of the same r in the same cycle: set wins (bit stays 1).
  - Updates happen only when ena=1.
  - issue_rdc=0 is ignored; bit 0 is forced to 0.
- Hazard (combinational from registered busy_map):
  - hazard = busy_map[chk_rsc] | busy_map[chk_rtc].
  - No bypass: a register cleared this cycle shows as not busy starting next cycle.
- Boundary cases:
  - All three sources valid continuously: grants rotate 0,1,2,0,… with one grant per cycle, so each source waits at most 2 cycles.
  - A transfer with a destination whose bit is already clear: write still performed, bit stays 0.
  - rst asserted mid-transfer cycle: reset wins, no write, scoreboard cleared.
  - ena low: pointer, scoreboard and rf_* outputs hold; rf_we is held too, so the integrator must gate writes at the register file with ena.

Test Plan:
- Reset, then ena=1, valid=001 with src0 rdc=5, data=0xDEADBEEF -> ready=001 same cycle; next cycle rf_we=1, rf_rdc=5, rf_rd=0xDEADBEEF; the following cycle rf_we=0.
- valid=111 held for 6 cycles, distinct rdc 1/2/3 -> grant sequence 001,010,100,001,010,100; rf_rdc sequence 1,2,3,1,2,3.
- issue_valid with issue_rdc=8, then chk_rsc=8 -> hazard=1, busy_map=0x100. Load source then writes r8 -> hazard=0 the cycle after the transfer.
- Same cycle: issue rdc=9 and ALU transfer rdc=9 with busy_map[9]=1 -> busy_map[9] stays 1, rf_we=1 to r9.
- src1 valid with rdc=0, data=0x1234 -> ready=010, rf_we stays 0, pointer advances (next all-valid grant goes to src2); issue_rdc=0 leaves busy_map=0.
- rst pulsed while valid=111 and busy_map=0xFFFFFFFE -> next cycle busy_map=0, rf_we=0; first grant after reset goes to src0. With ena=0 and valid=111 -> ready=000 and no state change.
